// File: rtl/time_date_editor.sv
// Editable BCD time/date register bank driven by debounced button pulses.
// Emits a one-cycle commit pulse after editing ends so the RTC writer can copy the values.
module time_date_editor (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        editar,
    input  logic        modo,
    input  logic        formato,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_right,
    input  logic        btn_left,
    output logic [23:0] datos_hora,
    output logic [23:0] datos_fecha,
    output logic        ampm,
    output logic [1:0]  cursor,
    output logic        commit,
    output logic [1:0]  dbg_state
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EDIT = 2'd1, S_COMMIT = 2'd2} state_t;

    state_t     r_state;
    logic [7:0] r_hora, r_min, r_seg, r_dia, r_mes, r_year;
    logic       r_ampm, r_commit;
    logic [1:0] r_cursor;

    logic [7:0] w_hora, w_min, w_seg, w_dia, w_mes, w_year, w_maxdia;
    logic       w_ampm, w_adj;
    logic [1:0] w_cursor;

    // Wrapping BCD step; out-of-range values snap to the opposite end.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo,
                                           input logic [7:0] hi);
        if (v >= hi)             return lo;
        else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                     return v + 8'd1;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lo,
                                           input logic [7:0] hi);
        if (v <= lo || v > hi)   return hi;
        else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        else                     return v - 8'd1;
    endfunction

    // Leap test on BCD year: even tens need units 0/4/8, odd tens need 2/6.
    function automatic logic [7:0] max_dia(input logic [7:0] mes, input logic [7:0] year);
        logic leap;
        leap = year[4] ? (year[3:0] == 4'd2 || year[3:0] == 4'd6)
                       : (year[3:0] == 4'd0 || year[3:0] == 4'd4 || year[3:0] == 4'd8);
        case (mes)
            8'h02:                      return leap ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                    return 8'h31;
        endcase
    endfunction

    always_comb begin
        w_hora   = r_hora;
        w_min    = r_min;
        w_seg    = r_seg;
        w_dia    = r_dia;
        w_mes    = r_mes;
        w_year   = r_year;
        w_ampm   = r_ampm;
        w_cursor = r_cursor;
        w_adj    = btn_up || btn_down;
        if (!editar) begin
            w_cursor = 2'd0;
        end else if (w_adj) begin
            case ({modo, r_cursor})
                3'b000: begin
                    if (!formato) begin
                        w_hora = btn_up ? bcd_inc(r_hora, 8'h00, 8'h23) : bcd_dec(r_hora, 8'h00, 8'h23);
                    end else if (r_hora == 8'h00 || r_hora > 8'h12) begin
                        w_hora = btn_up ? 8'h01 : 8'h12;
                    end else begin
                        w_hora = btn_up ? bcd_inc(r_hora, 8'h01, 8'h12) : bcd_dec(r_hora, 8'h01, 8'h12);
                        if (btn_up ? (r_hora == 8'h11 || r_hora == 8'h12)
                                   : (r_hora == 8'h01 || r_hora == 8'h12))
                            w_ampm = ~r_ampm;
                    end
                end
                3'b001: w_min  = btn_up ? bcd_inc(r_min, 8'h00, 8'h59) : bcd_dec(r_min, 8'h00, 8'h59);
                3'b010: w_seg  = btn_up ? bcd_inc(r_seg, 8'h00, 8'h59) : bcd_dec(r_seg, 8'h00, 8'h59);
                3'b100: w_dia  = btn_up ? bcd_inc(r_dia, 8'h01, max_dia(r_mes, r_year))
                                        : bcd_dec(r_dia, 8'h01, max_dia(r_mes, r_year));
                3'b101: w_mes  = btn_up ? bcd_inc(r_mes, 8'h01, 8'h12) : bcd_dec(r_mes, 8'h01, 8'h12);
                3'b110: w_year = btn_up ? bcd_inc(r_year, 8'h00, 8'h99) : bcd_dec(r_year, 8'h00, 8'h99);
                default: ;
            endcase
        end else if (btn_right) begin
            w_cursor = (r_cursor == 2'd2) ? 2'd0 : r_cursor + 2'd1;
        end else if (btn_left) begin
            w_cursor = (r_cursor == 2'd0) ? 2'd2 : r_cursor - 2'd1;
        end
        // Month/year changes can shrink the month; pull the day down in the same update.
        w_maxdia = max_dia(w_mes, w_year);
        if (w_dia > w_maxdia) w_dia = w_maxdia;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_hora   <= 8'h00;
            r_min    <= 8'h00;
            r_seg    <= 8'h00;
            r_dia    <= 8'h01;
            r_mes    <= 8'h01;
            r_year   <= 8'h00;
            r_ampm   <= 1'b0;
            r_cursor <= 2'd0;
            r_commit <= 1'b0;
        end else begin
            r_hora   <= w_hora;
            r_min    <= w_min;
            r_seg    <= w_seg;
            r_dia    <= w_dia;
            r_mes    <= w_mes;
            r_year   <= w_year;
            r_ampm   <= w_ampm;
            r_cursor <= w_cursor;
            if (editar) begin
                r_state  <= S_EDIT;
                r_commit <= 1'b0;
            end else if (r_state == S_EDIT) begin
                r_state  <= S_COMMIT;
                r_commit <= 1'b1;
            end else begin
                r_state  <= S_IDLE;
                r_commit <= 1'b0;
            end
        end
    end

    assign datos_hora  = {r_hora, r_min, r_seg};
    assign datos_fecha = {r_dia, r_mes, r_year};
    assign ampm        = r_ampm;
    assign cursor      = r_cursor;
    assign commit      = r_commit;
    assign dbg_state   = r_state;
endmodule

// File: tb/tb_time_date_editor.sv
// Bench for time_date_editor: directed edit sequences plus random button traffic,
// checked against an integer calendar/clock model.
module tb_time_date_editor;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        editar = 1'b0, modo = 1'b0, formato = 1'b0;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_right = 1'b0, btn_left = 1'b0;
    logic [23:0] datos_hora, datos_fecha;
    logic        ampm, commit;
    logic [1:0]  cursor, dbg_state;

    int compared = 0;
    int mismatched = 0;
    int m_h, m_mi, m_s, m_d, m_mo, m_y, m_ap, m_cur, m_commit, m_prev;

    time_date_editor dut (
        .clk(clk), .reset_n(reset_n), .editar(editar), .modo(modo), .formato(formato),
        .btn_up(btn_up), .btn_down(btn_down), .btn_right(btn_right), .btn_left(btn_left),
        .datos_hora(datos_hora), .datos_fecha(datos_fecha), .ampm(ampm),
        .cursor(cursor), .commit(commit), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int mdays(input int mo, input int y);
        if (mo == 2) return (y % 4 == 0) ? 29 : 28;
        if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
        return 31;
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_h = 0; m_mi = 0; m_s = 0; m_d = 1; m_mo = 1; m_y = 0;
        m_ap = 0; m_cur = 0; m_commit = 0; m_prev = 0;
    endtask

    // One clock edge of intended behaviour, using the inputs as sampled.
    task automatic model_step();
        bit up;
        up = btn_up;
        if (!editar) begin
            m_cur = 0;
        end else if (btn_up || btn_down) begin
            if (!modo) begin
                if (m_cur == 0) begin
                    if (!formato) m_h = up ? (m_h + 1) % 24 : (m_h + 23) % 24;
                    else if (m_h < 1 || m_h > 12) m_h = up ? 1 : 12;
                    else if (up) begin
                        if (m_h == 11 || m_h == 12) m_ap = 1 - m_ap;
                        m_h = m_h % 12 + 1;
                    end else begin
                        if (m_h == 1 || m_h == 12) m_ap = 1 - m_ap;
                        m_h = (m_h == 1) ? 12 : m_h - 1;
                    end
                end else if (m_cur == 1) m_mi = up ? (m_mi + 1) % 60 : (m_mi + 59) % 60;
                else m_s = up ? (m_s + 1) % 60 : (m_s + 59) % 60;
            end else begin
                if (m_cur == 0) begin
                    m_d = up ? m_d % mdays(m_mo, m_y) + 1 : ((m_d == 1) ? mdays(m_mo, m_y) : m_d - 1);
                end else begin
                    if (m_cur == 1) m_mo = up ? m_mo % 12 + 1 : ((m_mo == 1) ? 12 : m_mo - 1);
                    else m_y = up ? (m_y + 1) % 100 : (m_y + 99) % 100;
                    if (m_d > mdays(m_mo, m_y)) m_d = mdays(m_mo, m_y);
                end
            end
        end else if (btn_right) m_cur = (m_cur + 1) % 3;
        else if (btn_left) m_cur = (m_cur + 2) % 3;
        m_commit = (m_prev == 1 && !editar) ? 1 : 0;
        m_prev = editar ? 1 : 0;
    endtask

    task automatic check_all(input string tag);
        int st;
        st = editar ? 1 : (m_commit ? 2 : 0);
        chk({tag, " hora"}, datos_hora, {to_bcd(m_h), to_bcd(m_mi), to_bcd(m_s)});
        chk({tag, " fecha"}, datos_fecha, {to_bcd(m_d), to_bcd(m_mo), to_bcd(m_y)});
        chk({tag, " ampm"}, {23'd0, ampm}, 24'(m_ap));
        chk({tag, " cursor"}, {22'd0, cursor}, 24'(m_cur));
        chk({tag, " commit"}, {23'd0, commit}, 24'(m_commit));
        chk({tag, " state"}, {22'd0, dbg_state}, 24'(st));
    endtask

    task automatic step(input string tag, input logic up, input logic dn,
                        input logic r, input logic l);
        btn_up = up; btn_down = dn; btn_right = r; btn_left = l;
        @(posedge clk);
        model_step();
        #1;
        btn_up = 0; btn_down = 0; btn_right = 0; btn_left = 0;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #12 reset_n = 1'b1;
        @(posedge clk); #1;
        check_all("reset");

        // Minute wrap over a full lap.
        editar = 1; modo = 0; formato = 0;
        step("cur_right", 0, 0, 1, 0);
        for (int i = 0; i < 60; i++) step("min_up", 1, 0, 0, 0);
        chk("min_lap", datos_hora, 24'h000000);

        // 12 h hour arithmetic around 11/12/01.
        formato = 1;
        step("cur_left", 0, 0, 0, 1);
        for (int i = 0; i < 11; i++) step("h12_to11", 1, 0, 0, 0);
        chk("h12_at11", {datos_hora[23:16], 15'd0, ampm}, {8'h11, 16'd0});
        step("h12_up12", 1, 0, 0, 0);
        chk("h12_is12pm", {datos_hora[23:16], 15'd0, ampm}, {8'h12, 16'd1});
        step("h12_up01", 1, 0, 0, 0);
        chk("h12_is01", {16'd0, datos_hora[23:16]}, 24'h000001);
        step("h12_dn12", 0, 1, 0, 0);
        step("h12_dn11", 0, 1, 0, 0);
        chk("h12_back11am", {datos_hora[23:16], 15'd0, ampm}, {8'h11, 16'd0});

        // Date fields and day clamp on month/year change.
        modo = 1;
        step("dia_dn31", 0, 1, 0, 0);
        step("cur_y", 0, 0, 0, 1);
        step("year01", 1, 0, 0, 0);
        step("cur_m", 0, 0, 0, 1);
        step("mes02", 1, 0, 0, 0);
        chk("clamp_feb01", datos_fecha, 24'h280201);
        step("cur_y2", 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step("year_to04", 1, 0, 0, 0);
        step("cur_d", 0, 0, 1, 0);
        step("dia29", 1, 0, 0, 0);
        step("cur_y3", 0, 0, 0, 1);
        step("year05", 1, 0, 0, 0);
        chk("clamp_feb05", datos_fecha, 24'h280205);
        step("cur_m2", 0, 0, 0, 1);
        step("mes01", 0, 1, 0, 0);
        step("mes12", 0, 1, 0, 0);
        step("prio", 1, 0, 1, 1);
        chk("prio_fecha", datos_fecha, 24'h280105);
        chk("prio_cursor", {22'd0, cursor}, 24'd1);

        // Commit pulse, with a same-cycle button that must be ignored.
        editar = 0;
        step("fall", 1, 1, 1, 1);
        chk("commit_hi", {23'd0, commit}, 24'd1);
        chk("commit_fecha", datos_fecha, 24'h280105);
        step("after_commit", 0, 0, 0, 0);
        chk("commit_lo", {23'd0, commit}, 24'd0);

        // Reset during the fall cycle kills the commit.
        editar = 1;
        step("re_edit", 0, 0, 0, 0);
        step("edit_up", 1, 0, 0, 0);
        editar = 0;
        #2 reset_n = 0;
        model_reset();
        #1;
        check_all("async_rst");
        chk("async_rst_vals", datos_fecha ^ datos_hora, 24'h010100);
        @(negedge clk) reset_n = 1;
        step("no_commit", 0, 0, 0, 0);

        // Buttons while idle change nothing.
        for (int i = 0; i < 20; i++) begin
            modo = 1'($urandom_range(0, 1));
            step("idle_btn", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Random editing traffic.
        for (int i = 0; i < 600; i++) begin
            editar = ($urandom_range(0, 9) != 0);
            modo = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) formato = ~formato;
            step("rand", ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
